// File: rtl/instr_fetch_decode_pkg.sv
// Shared fetch/decode definitions: fetch FSM states, MIPS-style field positions and widths.
// Also used by the operand-prep and execute stages.
package instr_fetch_decode_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;

  localparam int OPC_HI = 31;
  localparam int OPC_LO = 26;
  localparam int RS_HI  = 25;
  localparam int RS_LO  = 21;
  localparam int RT_HI  = 20;
  localparam int RT_LO  = 16;
  localparam int RD_HI  = 15;
  localparam int RD_LO  = 11;
  localparam int IMM_HI = 15;
  localparam int IMM_LO = 0;

  localparam int OPC_W = OPC_HI - OPC_LO + 1;
  localparam int IMM_W = IMM_HI - IMM_LO + 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_HOLD
  } fetch_state_e;

endpackage

// File: rtl/instr_field_slicer.sv
// Combinational split of a 32-bit instruction word into opcode, register
// addresses and a sign-extended immediate.
module instr_field_slicer
  import instr_fetch_decode_pkg::*;
(
  input  logic [DATA_W-1:0]     instr,
  output logic [OPC_W-1:0]      opcode,
  output logic [REG_ADDR_W-1:0] rs,
  output logic [REG_ADDR_W-1:0] rt,
  output logic [REG_ADDR_W-1:0] rd,
  output logic [DATA_W-1:0]     imm
);

  assign opcode = instr[OPC_HI:OPC_LO];
  assign rs     = instr[RS_HI:RS_LO];
  assign rt     = instr[RT_HI:RT_LO];
  assign rd     = instr[RD_HI:RD_LO];
  assign imm    = {{(DATA_W - IMM_W){instr[IMM_HI]}}, instr[IMM_HI:IMM_LO]};

endmodule

// File: rtl/instr_fetch_decode.sv
// Fetch/decode stage: one outstanding imem request, field slicing, valid/ready output
// register, branch redirect/flush. Optional counters via `define FETCH_PERF_CNT_EN.
module instr_fetch_decode
  import instr_fetch_decode_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  Read_register1,
  output logic [4:0]  Read_register2,
  output logic [4:0]  Instruction_set3,
  output logic [31:0] Instruction_set4,
  output logic [5:0]  out_opcode,
  output logic [31:0] out_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_squashed
`endif
);

  fetch_state_e state, next_state;
  logic [31:0]  pc;
  logic         squash, squash_next;
  logic [31:0]  hold_buf;
  logic         load, store_buf, discard;
  logic [31:0]  load_word;

  logic [OPC_W-1:0]      s_opcode;
  logic [REG_ADDR_W-1:0] s_rs, s_rt, s_rd;
  logic [DATA_W-1:0]     s_imm;

  assign imem_req  = (state == ST_REQ);
  assign imem_addr = pc;
  assign load_word = (state == ST_HOLD) ? hold_buf : imem_rdata;

  instr_field_slicer u_slicer (
    .instr  (load_word),
    .opcode (s_opcode),
    .rs     (s_rs),
    .rt     (s_rt),
    .rd     (s_rd),
    .imm    (s_imm)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= next_state;
  end

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    next_state  = state;
    squash_next = squash;
    load        = 1'b0;
    store_buf   = 1'b0;
    discard     = 1'b0;
    unique case (state)
      ST_IDLE: next_state = ST_REQ;
      ST_REQ:  next_state = ST_WAIT;
      ST_WAIT: begin
        if (imem_rvalid) begin
          next_state = ST_REQ;
          if (squash) begin
            discard     = 1'b1;
            squash_next = 1'b0;
          end else if (!out_valid || out_ready) begin
            load = 1'b1;
          end else begin
            store_buf  = 1'b1;
            next_state = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          load       = 1'b1;
          next_state = ST_REQ;
        end
      end
      default: next_state = ST_IDLE;
    endcase

    // Redirect wins over any same-cycle response or consumer handshake.
    if (redirect_valid) begin
      load      = 1'b0;
      store_buf = 1'b0;
      discard   = 1'b0;
      unique case (state)
        ST_REQ: begin
          squash_next = 1'b1;
          next_state  = ST_WAIT;
        end
        ST_WAIT: begin
          if (imem_rvalid) begin
            discard     = 1'b1;
            squash_next = 1'b0;
            next_state  = ST_REQ;
          end else begin
            squash_next = 1'b1;
            next_state  = ST_WAIT;
          end
        end
        ST_HOLD: begin
          discard    = 1'b1;
          next_state = ST_REQ;
        end
        default: next_state = ST_REQ;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc               <= RESET_PC;
      squash           <= 1'b0;
      out_valid        <= 1'b0;
      Read_register1   <= '0;
      Read_register2   <= '0;
      Instruction_set3 <= '0;
      Instruction_set4 <= '0;
      out_opcode       <= '0;
      out_pc           <= '0;
    end else begin
      squash <= squash_next;
      if (redirect_valid) pc <= redirect_pc;
      else if (load)      pc <= pc + PC_STEP;

      if (redirect_valid) begin
        out_valid <= 1'b0;
      end else if (load) begin
        out_valid        <= 1'b1;
        Read_register1   <= s_rs;
        Read_register2   <= s_rt;
        Instruction_set3 <= s_rd;
        Instruction_set4 <= s_imm;
        out_opcode       <= s_opcode;
        out_pc           <= pc;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  // NOTE: the hold buffer carries data only; it is always written before HOLD reads it, so it needs no reset.
  always_ff @(posedge clk) begin
    if (store_buf) hold_buf <= imem_rdata;
  end

`ifdef FETCH_PERF_CNT_EN
  logic flush_entry;
  assign flush_entry = redirect_valid && out_valid && !out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_fetched  <= '0;
      perf_squashed <= '0;
    end else begin
      if (load) perf_fetched <= perf_fetched + 32'd1;
      perf_squashed <= perf_squashed + {31'd0, discard} + {31'd0, flush_entry};
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_decode.sv
// Directed bench for instr_fetch_decode: decode, backpressure/HOLD, redirect, reset, PC wrap.
module tb_instr_fetch_decode;

  logic        clk;
  logic        rst_n;
  logic        imem_rvalid, redirect_valid, out_ready;
  logic [31:0] imem_rdata, redirect_pc;
  logic        imem_req, out_valid;
  logic [31:0] imem_addr, out_pc, imm;
  logic [4:0]  rs, rt, rd;
  logic [5:0]  opcode;

  logic        w_rvalid, w_redirect_valid, w_out_ready;
  logic [31:0] w_rdata, w_redirect_pc;
  logic        w_req, w_out_valid;
  logic [31:0] w_addr, w_out_pc, w_imm;
  logic [4:0]  w_rs, w_rt, w_rd;
  logic [5:0]  w_opcode;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_squashed, w_perf_fetched, w_perf_squashed;
`endif

  int checks   = 0;
  int failures = 0;

  instr_fetch_decode dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .Read_register1(rs), .Read_register2(rt), .Instruction_set3(rd),
    .Instruction_set4(imm), .out_opcode(opcode), .out_pc(out_pc)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetched(perf_fetched), .perf_squashed(perf_squashed)
`endif
  );

  instr_fetch_decode #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst_n(rst_n),
    .imem_req(w_req), .imem_addr(w_addr),
    .imem_rvalid(w_rvalid), .imem_rdata(w_rdata),
    .redirect_valid(w_redirect_valid), .redirect_pc(w_redirect_pc),
    .out_valid(w_out_valid), .out_ready(w_out_ready),
    .Read_register1(w_rs), .Read_register2(w_rt), .Instruction_set3(w_rd),
    .Instruction_set4(w_imm), .out_opcode(w_opcode), .out_pc(w_out_pc)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetched(w_perf_fetched), .perf_squashed(w_perf_squashed)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst_n = 1'b0;
    tick();
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0h exp=0", out_valid); end
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL reset_imem_req got=%0h exp=0", imem_req); end
    checks++; if ({rs, rt, rd, imm, opcode, out_pc} !== '0) begin failures++; $display("FAIL reset_fields got=%0h/%0h/%0h/%0h/%0h/%0h exp=all 0", rs, rt, rd, imm, opcode, out_pc); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin failures++; $display("FAIL basic_first_req got req=%0h addr=%0h exp req=1 addr=0", imem_req, imem_addr); end
    out_ready = 1'b1;
    tick();
    imem_rvalid = 1'b1; imem_rdata = 32'h8C23_FFFC;
    tick();
    imem_rvalid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL basic_valid got=%0h exp=1", out_valid); end
    checks++; if (rs !== 5'd1 || rt !== 5'd3 || rd !== 5'd31) begin failures++; $display("FAIL basic_regs got rs=%0d rt=%0d rd=%0d exp 1/3/31", rs, rt, rd); end
    checks++; if (imm !== 32'hFFFF_FFFC || opcode !== 6'h23) begin failures++; $display("FAIL basic_imm_opc got imm=%0h opc=%0h exp fffffffc/23", imm, opcode); end
    checks++; if (out_pc !== 32'h0) begin failures++; $display("FAIL basic_out_pc got=%0h exp=0", out_pc); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin failures++; $display("FAIL basic_next_req got req=%0h addr=%0h exp req=1 addr=4", imem_req, imem_addr); end
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0;
    tick();
    imem_rvalid = 1'b1; imem_rdata = 32'h0022_1820;
    tick();
    imem_rvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++; if (out_valid !== 1'b1 || out_pc !== 32'h0 || rs !== 5'd1 || rt !== 5'd3) begin failures++; $display("FAIL hold_stable[%0d] got valid=%0h pc=%0h rs=%0d rt=%0d exp 1/0/1/3", i, out_valid, out_pc, rs, rt); end
      checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL hold_no_req[%0d] got=%0h exp=0", i, imem_req); end
      if (i < 3) tick();
    end
    out_ready = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h4) begin failures++; $display("FAIL hold_release got valid=%0h pc=%0h exp 1/4", out_valid, out_pc); end
    checks++; if (rs !== 5'd1 || rt !== 5'd2 || rd !== 5'd3 || imm !== 32'h0000_1820 || opcode !== 6'h0) begin failures++; $display("FAIL hold_fields got %0d/%0d/%0d/%0h/%0h exp 1/2/3/1820/0", rs, rt, rd, imm, opcode); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin failures++; $display("FAIL hold_next_req got req=%0h addr=%0h exp 1/8", imem_req, imem_addr); end
  endtask

  task automatic test_redirect_req;
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    tick();
    redirect_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL redir_req_flush got=%0h exp=0", out_valid); end
    tick();
    tick();
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_rvalid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL redir_req_discard got=%0h exp=0", out_valid); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin failures++; $display("FAIL redir_req_addr got req=%0h addr=%0h exp 1/100", imem_req, imem_addr); end
`ifdef FETCH_PERF_CNT_EN
    checks++; if (perf_squashed !== 32'd1) begin failures++; $display("FAIL redir_req_perf_sq got=%0d exp=1", perf_squashed); end
`endif
  endtask

  task automatic test_redirect_collide;
    tick();
    imem_rvalid = 1'b1; imem_rdata = 32'h2001_0005;
    tick();
    imem_rvalid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h100 || opcode !== 6'h08 || rt !== 5'd1 || imm !== 32'h5) begin failures++; $display("FAIL coll_pre got valid=%0h pc=%0h opc=%0h rt=%0d imm=%0h exp 1/100/8/1/5", out_valid, out_pc, opcode, rt, imm); end
    out_ready = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b1 || imem_addr !== 32'h104) begin failures++; $display("FAIL coll_wait got valid=%0h addr=%0h exp 1/104", out_valid, imem_addr); end
    imem_rvalid = 1'b1; imem_rdata = 32'hAC41_0008;
    out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h200;
    tick();
    imem_rvalid = 1'b0; redirect_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL coll_flush got=%0h exp=0", out_valid); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin failures++; $display("FAIL coll_addr got req=%0h addr=%0h exp 1/200", imem_req, imem_addr); end
`ifdef FETCH_PERF_CNT_EN
    checks++; if (perf_squashed !== 32'd2 || perf_fetched !== 32'd3) begin failures++; $display("FAIL coll_perf got sq=%0d fe=%0d exp 2/3", perf_squashed, perf_fetched); end
`endif
    tick();
    imem_rvalid = 1'b1; imem_rdata = 32'h1000_FFFF;
    tick();
    imem_rvalid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h200 || opcode !== 6'h04 || imm !== 32'hFFFF_FFFF) begin failures++; $display("FAIL coll_resume got valid=%0h pc=%0h opc=%0h imm=%0h exp 1/200/4/ffffffff", out_valid, out_pc, opcode, imm); end
    checks++; if (imem_addr !== 32'h204) begin failures++; $display("FAIL coll_resume_addr got=%0h exp=204", imem_addr); end
  endtask

  task automatic test_reset_mid;
    tick();
    rst_n = 1'b0;
    tick();
    tick();
    checks++; if (out_valid !== 1'b0 || out_pc !== 32'h0 || imem_req !== 1'b0) begin failures++; $display("FAIL rmid_reset got valid=%0h pc=%0h req=%0h exp 0/0/0", out_valid, out_pc, imem_req); end
`ifdef FETCH_PERF_CNT_EN
    checks++; if (perf_fetched !== 32'd0 || perf_squashed !== 32'd0) begin failures++; $display("FAIL rmid_perf got fe=%0d sq=%0d exp 0/0", perf_fetched, perf_squashed); end
`endif
    rst_n = 1'b1;
    imem_rvalid = 1'b1; imem_rdata = 32'hFFFF_FFFF;
    tick();
    imem_rvalid = 1'b0;
    checks++; if (out_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0) begin failures++; $display("FAIL rmid_stale got valid=%0h req=%0h addr=%0h exp 0/1/0", out_valid, imem_req, imem_addr); end
    tick();
    checks++; if (out_valid !== 1'b0 || imem_req !== 1'b0) begin failures++; $display("FAIL rmid_wait got valid=%0h req=%0h exp 0/0", out_valid, imem_req); end
  endtask

  task automatic test_wrap;
    checks++; if (w_req !== 1'b0 || w_addr !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_wait got req=%0h addr=%0h exp 0/fffffffc", w_req, w_addr); end
    w_rvalid = 1'b1; w_rdata = 32'h8C23_FFFC;
    tick();
    w_rvalid = 1'b0;
    checks++; if (w_out_valid !== 1'b1 || w_out_pc !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_load got valid=%0h pc=%0h exp 1/fffffffc", w_out_valid, w_out_pc); end
    checks++; if (w_req !== 1'b1 || w_addr !== 32'h0) begin failures++; $display("FAIL wrap_next got req=%0h addr=%0h exp 1/0", w_req, w_addr); end
  endtask

  initial begin
    rst_n = 1'b0;
    imem_rvalid = 1'b0; imem_rdata = '0;
    redirect_valid = 1'b0; redirect_pc = '0;
    out_ready = 1'b1;
    w_rvalid = 1'b0; w_rdata = '0;
    w_redirect_valid = 1'b0; w_redirect_pc = '0;
    w_out_ready = 1'b1;

    test_reset();
    test_basic();
    test_backpressure();
    test_redirect_req();
    test_redirect_collide();
    test_reset_mid();
    test_wrap();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
